// File: rtl/imem_pkg.sv
// imem_pkg: shared sizes and the loader FSM state encoding for instruction_memory
package imem_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam int IMEM_DEPTH = 256;
  typedef enum logic [2:0] {READY, LOAD_LEN, LOAD_LO, LOAD_HI, FLUSH} imem_state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: one write port, one registered read port; contents are never reset
module imem_array #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // only the read register is reset, so instruction comes up as zero
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/instruction_memory.sv
// instruction_memory: fetch RAM with byte-stream program loader; IMEM_PARITY_EN adds a stored even-parity bit
module instruction_memory #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int INSTR_W = imem_pkg::INSTR_W,
  parameter int DEPTH = imem_pkg::IMEM_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_instruction_address,
  output logic [INSTR_W-1:0] instruction,
  output logic               instruction_valid,
  input  logic               load_start,
  input  logic [7:0]         load_byte,
  input  logic               load_byte_valid,
  output logic               load_byte_ready,
  output logic               load_done,
  output logic               suspend_cpu,
  output logic               parity_error
);
  import imem_pkg::*;
`ifdef IMEM_PARITY_EN
  localparam int MW = INSTR_W + 1;
`else
  localparam int MW = INSTR_W;
`endif
  imem_state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [8:0] cnt;
  logic [7:0] lo;
  logic acc, we, re;
  logic [INSTR_W-1:0] word;
  logic [MW-1:0] wdata, rdata;
  assign acc = load_byte_valid & load_byte_ready;
  assign we = (state == LOAD_HI) & acc;
  assign re = (state == READY);
  assign word = INSTR_W'({load_byte, lo});
  assign instruction = rdata[INSTR_W-1:0];
`ifdef IMEM_PARITY_EN
  assign wdata = {^word, word};
  assign parity_error = instruction_valid & (^rdata);
`else
  assign wdata = word;
  assign parity_error = 1'b0;
`endif
  imem_array #(.AW(ADDR_W), .DW(MW), .DEPTH(DEPTH)) u_array (
    .clk(clk), .rst(rst), .we(we), .waddr(ptr), .wdata(wdata),
    .re(re), .raddr(pc_instruction_address), .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= READY;
      ptr <= '0;
      cnt <= '0;
      lo <= '0;
      instruction_valid <= 1'b0;
      load_byte_ready <= 1'b0;
      load_done <= 1'b0;
      suspend_cpu <= 1'b0;
    end else begin
      instruction_valid <= (state == READY);
      load_done <= 1'b0;
      case (state)
        READY: if (load_start) begin
          state <= LOAD_LEN;
          ptr <= '0;
          load_byte_ready <= 1'b1;
          suspend_cpu <= 1'b1;
        end
        LOAD_LEN: if (acc) begin
          cnt <= (load_byte == 8'd0) ? 9'd256 : {1'b0, load_byte};
          state <= LOAD_LO;
        end
        LOAD_LO: if (acc) begin
          lo <= load_byte;
          state <= LOAD_HI;
        end
        LOAD_HI: if (acc) begin
          ptr <= ptr + 1'b1;
          cnt <= cnt - 1'b1;
          state <= (cnt == 9'd1) ? FLUSH : LOAD_LO;
          load_byte_ready <= (cnt != 9'd1);
          load_done <= (cnt == 9'd1);
        end
        FLUSH: begin
          state <= READY;
          suspend_cpu <= 1'b0;
        end
        default: state <= READY;
      endcase
    end
endmodule
